// File: rtl/vinput_frame_collector.sv
// Collects J serial IEEE-754 double samples into one frame and tracks the argmax with integer key compares.
// Optional build macro VINPUT_NAN_CHECK_EN keeps NaNs out of the argmax and adds the nan_seen output.
module vinput_frame_collector #(
  parameter int J = 14,
  localparam int J_WIDTH = $clog2(J) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          vinput,
  input  logic                 vinput_tvalid,
  input  logic                 flush,
  output logic [J*64-1:0]      vec_out,
  output logic                 vec_tvalid,
  input  logic                 vec_tready,
  output logic [J_WIDTH-1:0]   max_idx,
  output logic [63:0]          max_val,
  output logic [J_WIDTH-1:0]   fill_count,
  output logic                 overflow
`ifdef VINPUT_NAN_CHECK_EN
  ,
  output logic                 nan_seen
`endif
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  localparam logic [J_WIDTH-1:0] IDX_ZERO = {J_WIDTH{1'b0}};
  localparam logic [J_WIDTH-1:0] IDX_LAST = J_WIDTH'(J - 1);

  // Order-preserving map of a double onto an unsigned integer; -0.0 lands just below +0.0.
  function automatic logic [63:0] fp_key(input logic [63:0] bits);
    fp_key = bits[63] ? ~bits : (bits ^ {1'b1, 63'd0});
  endfunction

`ifdef VINPUT_NAN_CHECK_EN
  function automatic logic fp_is_nan(input logic [63:0] bits);
    fp_is_nan = (bits[62:52] == 11'h7FF) && (bits[51:0] != 52'd0);
  endfunction
`endif

  state_t               state_r, state_s;
  logic [J*64-1:0]      vec_r;
  logic [J_WIDTH-1:0]   fill_r, fill_s;
  logic [J_WIDTH-1:0]   max_idx_r, max_idx_s;
  logic [63:0]          max_val_r, max_val_s;
  logic                 max_vld_r, max_vld_s;
  logic                 vec_tvalid_r, vec_tvalid_s;
  logic                 overflow_r, overflow_s;
  logic                 handshake_s;
  logic                 accept_s;
  logic                 first_s;
  logic                 base_vld_s;
  logic                 is_greater_s;
  logic                 take_s;
  logic [J_WIDTH-1:0]   wr_idx_s;
`ifdef VINPUT_NAN_CHECK_EN
  logic                 samp_nan_s;
  logic                 nan_acc_r, nan_acc_s;
  logic                 nan_seen_r, nan_seen_s;
`endif

  // Next-state, running-argmax and frame-control logic.
  always_comb begin
    handshake_s  = (state_r == ST_HOLD) && vec_tready;
    accept_s     = vinput_tvalid && ((state_r == ST_COLLECT) || handshake_s);
    // A sample that opens a frame never compares against leftover max state.
    first_s      = (state_r == ST_HOLD) || flush || (fill_r == IDX_ZERO);
    wr_idx_s     = first_s ? IDX_ZERO : fill_r;
    base_vld_s   = first_s ? 1'b0 : max_vld_r;
    is_greater_s = fp_key(vinput) > fp_key(max_val_r);
`ifdef VINPUT_NAN_CHECK_EN
    samp_nan_s   = fp_is_nan(vinput);
    take_s       = accept_s && !samp_nan_s && (!base_vld_s || is_greater_s);
    nan_acc_s    = nan_acc_r;
    nan_seen_s   = nan_seen_r;
`else
    take_s       = accept_s && (!base_vld_s || is_greater_s);
`endif
    state_s      = state_r;
    fill_s       = fill_r;
    max_idx_s    = max_idx_r;
    max_val_s    = max_val_r;
    max_vld_s    = max_vld_r;
    vec_tvalid_s = vec_tvalid_r;
    overflow_s   = overflow_r;

    case (state_r)
      ST_COLLECT: begin
        if (flush) begin
          fill_s    = IDX_ZERO;
          max_vld_s = 1'b0;
          max_idx_s = IDX_ZERO;
          max_val_s = 64'd0;
`ifdef VINPUT_NAN_CHECK_EN
          nan_acc_s = 1'b0;
`endif
        end else begin
          fill_s = fill_r;
        end
      end
      ST_HOLD: begin
        if (handshake_s) begin
          state_s      = ST_COLLECT;
          vec_tvalid_s = 1'b0;
`ifdef VINPUT_NAN_CHECK_EN
          nan_seen_s   = 1'b0;
`endif
        end else if (vinput_tvalid) begin
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
      end
      default: begin
        state_s      = ST_COLLECT;
        vec_tvalid_s = 1'b0;
        fill_s       = IDX_ZERO;
      end
    endcase

    if (accept_s) begin
      if (first_s) begin
        max_vld_s = 1'b0;
        max_idx_s = IDX_ZERO;
        max_val_s = 64'd0;
`ifdef VINPUT_NAN_CHECK_EN
        nan_acc_s = 1'b0;
`endif
      end else begin
        max_vld_s = max_vld_r;
      end
      if (take_s) begin
        max_vld_s = 1'b1;
        max_idx_s = wr_idx_s;
        max_val_s = vinput;
      end else begin
        max_vld_s = max_vld_s;
      end
`ifdef VINPUT_NAN_CHECK_EN
      nan_acc_s = nan_acc_s | samp_nan_s;
`endif
      if (wr_idx_s == IDX_LAST) begin
        state_s      = ST_HOLD;
        vec_tvalid_s = 1'b1;
        fill_s       = IDX_ZERO;
`ifdef VINPUT_NAN_CHECK_EN
        nan_seen_s   = nan_acc_s;
        // An all-NaN frame reports the canonical quiet NaN at index 0.
        if (!max_vld_s) begin
          max_idx_s = IDX_ZERO;
          max_val_s = 64'h7FF8000000000000;
        end else begin
          max_idx_s = max_idx_s;
        end
`endif
        max_vld_s    = 1'b0;
      end else begin
        fill_s = wr_idx_s + J_WIDTH'(1);
      end
    end else begin
      fill_s = fill_s;
    end
  end

  // Control and argmax registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_COLLECT;
      fill_r       <= IDX_ZERO;
      max_idx_r    <= IDX_ZERO;
      max_val_r    <= 64'd0;
      max_vld_r    <= 1'b0;
      vec_tvalid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      fill_r       <= fill_s;
      max_idx_r    <= max_idx_s;
      max_val_r    <= max_val_s;
      max_vld_r    <= max_vld_s;
      vec_tvalid_r <= vec_tvalid_s;
      overflow_r   <= overflow_s;
    end
  end

`ifdef VINPUT_NAN_CHECK_EN
  // Per-frame NaN tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nan_acc_r  <= 1'b0;
      nan_seen_r <= 1'b0;
    end else begin
      nan_acc_r  <= nan_acc_s;
      nan_seen_r <= nan_seen_s;
    end
  end

  assign nan_seen = nan_seen_r;
`endif

  // Frame storage; only the element addressed by an accepted sample changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_r <= {(J*64){1'b0}};
    end else begin
      for (int k = 0; k < J; k++) begin
        if (accept_s && (wr_idx_s == J_WIDTH'(k))) begin
          vec_r[k*64 +: 64] <= vinput;
        end else begin
          vec_r[k*64 +: 64] <= vec_r[k*64 +: 64];
        end
      end
    end
  end

  assign vec_out    = vec_r;
  assign vec_tvalid = vec_tvalid_r;
  assign max_idx    = max_idx_r;
  assign max_val    = max_val_r;
  assign fill_count = fill_r;
  assign overflow   = overflow_r;

endmodule
